// File: rtl/bus_req_arbiter.sv
// Two-requester round-robin arbiter in front of a single register slave.
// One transaction in flight at a time: IDLE -> ISSUE (strobe) -> WAIT (done/timeout) -> RESP (ack).
module bus_req_arbiter #(
    parameter int unsigned AW      = 14,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rq0_rd_i,
    input  logic          rq0_wr_i,
    input  logic [AW-1:0] rq0_addr_i,
    input  logic [31:0]   rq0_wdata_i,
    output logic          rq0_ack_o,
    output logic          rq0_err_o,
    output logic [31:0]   rq0_rdata_o,
    input  logic          rq1_rd_i,
    input  logic          rq1_wr_i,
    input  logic [AW-1:0] rq1_addr_i,
    input  logic [31:0]   rq1_wdata_i,
    output logic          rq1_ack_o,
    output logic          rq1_err_o,
    output logic [31:0]   rq1_rdata_o,
    output logic          s_rd_o,
    output logic          s_wr_o,
    output logic [AW-1:0] s_addr_o,
    output logic [31:0]   s_wdata_o,
    input  logic [31:0]   s_rdata_i,
    input  logic          s_rd_done_i,
    input  logic          s_wr_done_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            grant_q;
    logic            last_q;
    logic            read_q;
    logic            err_q;
    logic [7:0]      cnt_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata0_q, rdata1_q;

    logic            req0, req1, any_req;
    logic            pick, pick_read;
    logic            match_done, expire;

    always_comb begin
        req0      = rq0_rd_i | rq0_wr_i;
        req1      = rq1_rd_i | rq1_wr_i;
        any_req   = req0 | req1;
        // On a tie, favour whoever was not granted last; otherwise the sole requester.
        pick      = (req0 && req1) ? ~last_q : req1;
        // A simultaneous rd+wr is served as a read; the write stays pending.
        pick_read = pick ? rq1_rd_i : rq0_rd_i;
        match_done = read_q ? s_rd_done_i : s_wr_done_i;
        expire     = (cnt_q == CntMax);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (match_done || expire) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            read_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        grant_q <= pick;
                        read_q  <= pick_read;
                        addr_q  <= pick ? rq1_addr_i : rq0_addr_i;
                        wdata_q <= pick ? rq1_wdata_i : rq0_wdata_i;
                    end
                end
                StIssue: cnt_q <= 8'd0;
                StWait: begin
                    if (match_done || expire) begin
                        // A done landing on the expiry cycle still counts as success.
                        err_q <= ~match_done;
                        if (read_q) begin
                            if (grant_q) rdata1_q <= match_done ? s_rdata_i : 32'hFFFF_FFFF;
                            else         rdata0_q <= match_done ? s_rdata_i : 32'hFFFF_FFFF;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp: last_q <= grant_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        s_rd_o      = (state_q == StIssue) &&  read_q;
        s_wr_o      = (state_q == StIssue) && !read_q;
        busy_o      = (state_q != StIdle);
        rq0_ack_o   = (state_q == StResp) && !grant_q;
        rq1_ack_o   = (state_q == StResp) &&  grant_q;
        rq0_err_o   = rq0_ack_o && err_q;
        rq1_err_o   = rq1_ack_o && err_q;
        rq0_rdata_o = rdata0_q;
        rq1_rdata_o = rdata1_q;
        s_addr_o    = addr_q;
        s_wdata_o   = wdata_q;
    end

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Bench for bus_req_arbiter: directed scenarios plus random traffic, checked per cycle
// against a transaction-level model (winner, ack cycle, error, returned data).
module tb_bus_req_arbiter;

    localparam int AW = 14;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd [2];
    logic          wr [2];
    logic [AW-1:0] addr [2];
    logic [31:0]   wdata [2];
    logic          ack0, ack1, err0, err1;
    logic [31:0]   rdata0, rdata1;
    logic          s_rd, s_wr, busy;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata, s_rdata;
    logic          s_rd_done, s_wr_done;

    int            tests = 0;
    int            fails = 0;
    int            lastg;
    logic [31:0]   mrdata [2];
    bit            rearm = 1'b0;
    int            prev_w = 0;
    bit            prev_rd = 1'b0;

    bus_req_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rq0_rd_i    (rd[0]),
        .rq0_wr_i    (wr[0]),
        .rq0_addr_i  (addr[0]),
        .rq0_wdata_i (wdata[0]),
        .rq0_ack_o   (ack0),
        .rq0_err_o   (err0),
        .rq0_rdata_o (rdata0),
        .rq1_rd_i    (rd[1]),
        .rq1_wr_i    (wr[1]),
        .rq1_addr_i  (addr[1]),
        .rq1_wdata_i (wdata[1]),
        .rq1_ack_o   (ack1),
        .rq1_err_o   (err1),
        .rq1_rdata_o (rdata1),
        .s_rd_o      (s_rd),
        .s_wr_o      (s_wr),
        .s_addr_o    (s_addr),
        .s_wdata_o   (s_wdata),
        .s_rdata_i   (s_rdata),
        .s_rd_done_i (s_rd_done),
        .s_wr_done_i (s_wr_done),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit pending();
        return rd[0] | wr[0] | rd[1] | wr[1];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0;
            wr[i] = 1'b0;
            mrdata[i] = 32'd0;
        end
        s_rd_done = 1'b0;
        s_wr_done = 1'b0;
        tick();
        rst_n = 1'b1;
        lastg = 1;
    endtask

    // Called at the negedge of the IDLE cycle in which requests are sampled (cycle 0).
    // d: strobe-to-done delay; outside 1..TO the slave never answers.
    task automatic serve(input int d, input logic [31:0] rv, input bit wrong);
        int   w;
        int   ackc;
        bit   isrd, to;
        bit   r0, r1;
        logic m, o;
        r0   = rd[0] | wr[0];
        r1   = rd[1] | wr[1];
        w    = (r0 && r1) ? 1 - lastg : (r1 ? 1 : 0);
        isrd = rd[w];
        to   = (d < 1 || d > TO);
        ackc = to ? TO + 2 : d + 2;
        check("idle_busy", busy, 1'b0);
        check("idle_strobe", {s_rd, s_wr}, 2'b00);
        for (int n = 1; n <= ackc; n++) begin
            tick();
            check("busy", busy, 1'b1);
            check("s_rd", s_rd, (n == 1) && isrd);
            check("s_wr", s_wr, (n == 1) && !isrd);
            if (n == 1) begin
                check("s_addr", s_addr, addr[w]);
                check("s_wdata", s_wdata, wdata[w]);
                if (rearm) begin
                    if (prev_rd) rd[prev_w] = 1'b1;
                    else         wr[prev_w] = 1'b1;
                end
            end
            check("ack0", ack0, (n == ackc) && (w == 0));
            check("ack1", ack1, (n == ackc) && (w == 1));
            check("err0", err0, (n == ackc) && (w == 0) && to);
            check("err1", err1, (n == ackc) && (w == 1) && to);
            if (n == ackc) begin
                if (isrd) mrdata[w] = to ? 32'hFFFF_FFFF : rv;
                check("rdata0", rdata0, mrdata[0]);
                check("rdata1", rdata1, mrdata[1]);
            end
            // Slave side for the remainder of cycle n.
            s_rdata = $urandom;
            o = wrong ? 1'b1 : 1'($urandom_range(0, 1));
            if (!to && n == 1 + d) begin
                m = 1'b1;
                s_rdata = rv;
            end else if (n == 1 || n == ackc) begin
                m = 1'($urandom_range(0, 1));
            end else begin
                m = 1'b0;
            end
            s_rd_done = isrd ? m : o;
            s_wr_done = isrd ? o : m;
        end
        if (isrd) rd[w] = 1'b0;
        else      wr[w] = 1'b0;
        lastg   = w;
        prev_w  = w;
        prev_rd = isrd;
    endtask

    task automatic rand_requests();
        int mask;
        mask = $urandom_range(1, 3);
        for (int i = 0; i < 2; i++) begin
            if (mask[i]) begin
                int op;
                op = $urandom_range(0, 2);
                rd[i]    = (op != 1);
                wr[i]    = (op != 0);
                addr[i]  = AW'($urandom);
                wdata[i] = $urandom;
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && pending(); k++) begin
            serve($urandom_range(1, 4), $urandom, 1'b0);
            tick();
        end
        check("drained", 32'(pending()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        s_rdata   = 32'd0;
        s_rd_done = 1'b0;
        s_wr_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = 32'd0;
        end
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_ack", {ack0, ack1}, 2'b00);
        check("rst_err", {err0, err1}, 2'b00);
        check("rst_strobe", {s_rd, s_wr}, 2'b00);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        check("rst_s_wdata", s_wdata, 32'd0);
        do_reset();

        // Single read, done two cycles after the strobe.
        rd[0] = 1'b1; addr[0] = '0;
        serve(2, 32'h0000_2A05, 1'b0);
        tick();
        check("single_rdata", rdata0, 32'h0000_2A05);

        // Contention from reset: rq0 first, then rq1.
        do_reset();
        wr[0] = 1'b1; wr[1] = 1'b1;
        addr[0] = AW'($urandom); addr[1] = AW'($urandom);
        wdata[0] = $urandom; wdata[1] = $urandom;
        serve(1, 32'd0, 1'b0);
        tick();
        serve(3, 32'd0, 1'b0);
        tick();
        check("contention_idle", busy, 1'b0);

        // Fairness: both keep re-requesting.
        do_reset();
        rand_requests();
        rd[0] = 1'b1; rd[1] = 1'b0; wr[1] = 1'b1;
        rearm = 1'b1;
        for (int k = 0; k < 6; k++) begin
            serve($urandom_range(1, 5), $urandom, 1'b0);
            tick();
        end
        rearm = 1'b0;
        drain();

        // rd+wr together: read first, write remains pending.
        rd[1] = 1'b1; wr[1] = 1'b1;
        serve(2, 32'hCAFE_0001, 1'b0);
        tick();
        check("rdwr_wr_pending", wr[1], 1'b1);
        serve(2, 32'd0, 1'b0);
        tick();

        // Timeout on a read.
        do_reset();
        rd[0] = 1'b1; addr[0] = AW'(5);
        serve(0, 32'd0, 1'b0);
        tick();
        check("timeout_idle", busy, 1'b0);
        check("timeout_rdata", rdata0, 32'hFFFF_FFFF);

        // Done on the expiry cycle wins over timeout.
        rd[1] = 1'b1;
        serve(TO, 32'h1234_5678, 1'b0);
        tick();
        wr[0] = 1'b1;
        serve(TO, 32'd0, 1'b0);
        tick();

        // Wrong done on a pending write: success path and timeout path.
        wr[0] = 1'b1;
        serve(5, 32'd0, 1'b1);
        tick();
        wr[1] = 1'b1;
        serve(0, 32'd0, 1'b1);
        tick();

        // Reset in WAIT, then a late write done.
        do_reset();
        wr[0] = 1'b1; addr[0] = AW'(9);
        tick();
        check("mid_issue_strobe", s_wr, 1'b1);
        tick();
        tick();
        rst_n = 1'b0; wr[0] = 1'b0;
        tick();
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ack", ack0, 1'b0);
        rst_n = 1'b1; lastg = 1; mrdata[0] = 32'd0; mrdata[1] = 32'd0;
        s_wr_done = 1'b1;
        tick();
        check("late_done_ack", {ack0, ack1}, 2'b00);
        check("late_done_busy", busy, 1'b0);
        tick();
        check("late_done_busy2", busy, 1'b0);
        s_wr_done = 1'b0;
        rd[1] = 1'b1; addr[1] = AW'(3);
        serve(3, 32'hA5A5_0F0F, 1'b0);
        tick();

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            if (!pending()) rand_requests();
            serve($urandom_range(0, TO + 1), $urandom, 1'($urandom_range(0, 3) == 0));
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
